// File: rtl/multicycle_cpu.sv
// Multi-cycle CPU: writable instruction memory, FETCH/DECODE/EXEC/WB sequencing,
// step/run modes and HALT. Define CPU_DBG_EN to add a side-effect-free register read port.
module multicycle_cpu #(
  parameter int DATA_W     = 32,
  parameter int REG_N      = 32,
  parameter int IMEM_DEPTH = 8,
  localparam int PC_W      = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step,
  input  logic              load_we,
  input  logic [PC_W-1:0]   load_addr,
  input  logic [31:0]       load_data,
  output logic              busy,
  output logic              halted,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic [4:0]        wb_rd,
  output logic [15:0]       instr_count
`ifdef CPU_DBG_EN
  ,
  input  logic [4:0]        dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
`endif
);

  localparam int SH_W = $clog2(DATA_W);

  localparam logic [2:0] OP_NOOP = 3'b000;
  localparam logic [2:0] OP_HALT = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_ADDI = 3'b110;
  localparam logic [2:0] OP_SUBI = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  function automatic logic [DATA_W-1:0] sext5(input logic [4:0] imm);
    return {{(DATA_W-5){imm[4]}}, imm};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  // Only the decoded fields [31:14] are stored; the low bits carry no meaning.
  logic [17:0]       imem_r [IMEM_DEPTH];
  logic [DATA_W-1:0] rf_r [1:REG_N-1];

  state_t            state_r, state_next_s;
  logic              busy_r, halted_r, busy_next_s;
  logic [PC_W-1:0]   pc_r, pc_inc_s;
  logic [17:0]       ir_r;
  logic [DATA_W-1:0] a_r, b_r, alu_r, alu_s;
  logic [DATA_W-1:0] rd_a_s, rd_b_s, b_sel_s;
  logic [DATA_W-1:0] result_r;
  logic              result_valid_r;
  logic [4:0]        wb_rd_r;
  logic [15:0]       instr_count_r;
  logic [2:0]        op_s;
  logic [4:0]        rd_s, rs1_s, rs2_s;
  logic              unused_load_s;

  assign op_s          = ir_r[17:15];
  assign rd_s          = ir_r[14:10];
  assign rs1_s         = ir_r[9:5];
  assign rs2_s         = ir_r[4:0];
  assign unused_load_s = ^load_data[13:0];

  assign busy         = busy_r;
  assign halted       = halted_r;
  assign pc           = pc_r;
  assign result       = result_r;
  assign result_valid = result_valid_r;
  assign wb_rd        = wb_rd_r;
  assign instr_count  = instr_count_r;

  // Next-state decode; run wins over step, and step outside IDLE is simply dropped.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:   state_next_s = (run || step) ? ST_FETCH : ST_IDLE;
      ST_FETCH:  state_next_s = ST_DECODE;
      ST_DECODE: state_next_s = ST_EXEC;
      ST_EXEC:   state_next_s = (op_s == OP_HALT) ? ST_HALT : ST_WB;
      ST_WB:     state_next_s = run ? ST_FETCH : ST_IDLE;
      ST_HALT:   state_next_s = ST_HALT;
      default:   state_next_s = ST_IDLE;
    endcase
    busy_next_s = (state_next_s == ST_FETCH) || (state_next_s == ST_DECODE) ||
                  (state_next_s == ST_EXEC)  || (state_next_s == ST_WB);
  end

  // State register with busy/halted registered from the next state so they track it exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      busy_r   <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      busy_r   <= busy_next_s;
      halted_r <= (state_next_s == ST_HALT);
    end
  end

  // Two register-file read ports for the operands; r0 and out-of-range indices read zero.
  always_comb begin
    rd_a_s = {DATA_W{1'b0}};
    rd_b_s = {DATA_W{1'b0}};
    for (int i = 1; i < REG_N; i++) begin
      rd_a_s = (rs1_s == 5'(i)) ? rf_r[i] : rd_a_s;
      rd_b_s = (rs2_s == 5'(i)) ? rf_r[i] : rd_b_s;
    end
    b_sel_s = ((op_s == OP_ADDI) || (op_s == OP_SUBI)) ? sext5(rs2_s) : rd_b_s;
  end

  // ALU; shifts use only the low log2(DATA_W) bits of B.
  always_comb begin
    alu_s = {DATA_W{1'b0}};
    case (op_s)
      OP_ADD, OP_ADDI: alu_s = a_r + b_r;
      OP_SUB, OP_SUBI: alu_s = a_r - b_r;
      OP_SHL:          alu_s = a_r << b_r[SH_W-1:0];
      OP_SHR:          alu_s = a_r >> b_r[SH_W-1:0];
      default:         alu_s = {DATA_W{1'b0}};
    endcase
    pc_inc_s = (pc_r == PC_W'(IMEM_DEPTH - 1)) ? {PC_W{1'b0}} : pc_r + PC_W'(1);
  end

  // Instruction memory load port; reset leaves contents intact.
  always_ff @(posedge clk) begin
    if (!rst && load_we && ((state_r == ST_IDLE) || (state_r == ST_HALT))) begin
      imem_r[load_addr] <= load_data[31:14];
    end
  end

  // Register file write in WB; NOOP and r0 never write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < REG_N; i++) begin
        rf_r[i] <= {DATA_W{1'b0}};
      end
    end else if ((state_r == ST_WB) && (op_s != OP_NOOP)) begin
      for (int i = 1; i < REG_N; i++) begin
        if (rd_s == 5'(i)) begin
          rf_r[i] <= alu_r;
        end
      end
    end
  end

  // Datapath pipeline registers, program counter and retirement bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r           <= {PC_W{1'b0}};
      ir_r           <= 18'd0;
      a_r            <= {DATA_W{1'b0}};
      b_r            <= {DATA_W{1'b0}};
      alu_r          <= {DATA_W{1'b0}};
      result_r       <= {DATA_W{1'b0}};
      result_valid_r <= 1'b0;
      wb_rd_r        <= 5'd0;
      instr_count_r  <= 16'd0;
    end else begin
      result_valid_r <= 1'b0;
      case (state_r)
        ST_FETCH: ir_r <= imem_r[pc_r];
        ST_DECODE: begin
          a_r <= rd_a_s;
          b_r <= b_sel_s;
        end
        ST_EXEC: begin
          alu_r <= alu_s;
          if (op_s == OP_HALT) begin
            instr_count_r <= sat_inc(instr_count_r);
          end
        end
        ST_WB: begin
          if (op_s != OP_NOOP) begin
            result_r       <= alu_r;
            wb_rd_r        <= rd_s;
            result_valid_r <= 1'b1;
          end
          pc_r          <= pc_inc_s;
          instr_count_r <= sat_inc(instr_count_r);
        end
        default: ;
      endcase
    end
  end

`ifdef CPU_DBG_EN
  // Debug read port: purely combinational, same zero rules as the operand ports.
  always_comb begin
    dbg_rdata = {DATA_W{1'b0}};
    for (int i = 1; i < REG_N; i++) begin
      dbg_rdata = (dbg_raddr == 5'(i)) ? rf_r[i] : dbg_rdata;
    end
  end
`endif

endmodule
